// File: rtl/ppu_cpu_readback_if.sv
// Avalon-MM slave bus between the CPU and the PPU read responder.
interface ppu_cpu_readback_if;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [11:0] address;
  logic [31:0] write_data;
  logic [31:0] readdata;
  logic        waitrequest;

  modport master (
    output chipselect, read, write, address, write_data,
    input  readdata, waitrequest
  );

  modport slave (
    input  chipselect, read, write, address, write_data,
    output readdata, waitrequest
  );
endinterface

// File: rtl/ppu_cpu_readback.sv
// CPU read responder, status/control window, frame counter and vblank IRQ for the PPU.
// Build option: PPU_RD_VBLANK_GATE_EN holds memory-region reads in IDLE until vblank is high.
module ppu_cpu_readback #(
  parameter int MEM_LAT = 1,
  parameter int FRAME_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  ppu_cpu_readback_if.slave  bus,
  input  logic               i_vblank,
  output logic               o_irq,
  output logic [4:0]         o_mem_sel,
  output logic               o_mem_rd,
  output logic [10:0]        o_mem_addr,
  input  logic [31:0]        i_tile_buffer_rdata,
  input  logic [31:0]        i_tile_graphics_rdata,
  input  logic [31:0]        i_sprite_graphics_rdata,
  input  logic [31:0]        i_oam_rdata,
  input  logic [23:0]        i_palette_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [11:0] A_STATUS  = 12'h3F0;
  localparam logic [11:0] A_CTRL    = 12'h3F1;
  localparam logic [11:0] A_IRQ_ACK = 12'h3F2;
  localparam logic [4:0]  SEL_TBUF  = 5'b00001;
  localparam logic [4:0]  SEL_TGFX  = 5'b00010;
  localparam logic [4:0]  SEL_SGFX  = 5'b00100;
  localparam logic [4:0]  SEL_OAM   = 5'b01000;
  localparam logic [4:0]  SEL_PAL   = 5'b10000;
  localparam logic [1:0]  LAT_M1    = 2'(MEM_LAT - 1);

  state_t             r_state;
  state_t             w_next;
  logic [1:0]         r_cnt;
  logic [31:0]        r_readdata;
  logic               r_irq_en;
  logic               r_gfx_bank;
  logic               r_irq_pending;
  logic               r_vblank_q;
  logic               r_status_rd;
  logic [FRAME_W-1:0] r_frame_count;

  logic        w_rd_req;
  logic        w_wr_req;
  logic [4:0]  w_sel_dec;
  logic        w_mem_ok;
  logic        w_start_mem;
  logic        w_start_reg;
  logic        w_capture_mem;
  logic [31:0] w_reg_rdata;
  logic [31:0] w_mem_rdata;
  logic [15:0] w_frame_ext;
  logic        w_vb_rise;
  logic        w_pend_set;
  logic        w_pend_clr;
  logic        w_unused_wdata;

  function automatic logic [4:0] f_mem_sel(input logic [11:0] a, input logic bank);
    if (a[11]) begin
      f_mem_sel = bank ? SEL_SGFX : SEL_TGFX;
    end else if (a[11:9] == 3'b000) begin
      f_mem_sel = SEL_TBUF;
    end else if (a[11:8] == 4'b0010) begin
      f_mem_sel = SEL_OAM;
    end else if (a[11:3] == 9'h060) begin
      f_mem_sel = SEL_PAL;
    end else begin
      f_mem_sel = 5'b00000;
    end
  endfunction

  function automatic logic [10:0] f_mem_index(input logic [11:0] a);
    if (a[11]) begin
      f_mem_index = a[10:0];
    end else if (a[11:9] == 3'b000) begin
      f_mem_index = {2'b00, a[8:0]};
    end else if (a[11:8] == 4'b0010) begin
      f_mem_index = {3'b000, a[7:0]};
    end else if (a[11:3] == 9'h060) begin
      f_mem_index = {8'h00, a[2:0]};
    end else begin
      f_mem_index = 11'd0;
    end
  endfunction

  assign w_rd_req       = bus.chipselect && bus.read;
  assign w_wr_req       = bus.chipselect && bus.write && !bus.read;
  assign w_sel_dec      = f_mem_sel(bus.address, r_gfx_bank);
  assign w_frame_ext    = 16'(r_frame_count);
  assign w_vb_rise      = i_vblank && !r_vblank_q;
  assign w_unused_wdata = ^bus.write_data[31:2];
  // Stall is dropped during reset so an interrupted transfer cannot hang the bus.
  assign bus.waitrequest = rst_n && w_rd_req && (r_state != S_DONE);
  assign bus.readdata    = r_readdata;

`ifdef PPU_RD_VBLANK_GATE_EN
  assign w_mem_ok = i_vblank;
`else
  assign w_mem_ok = 1'b1;
`endif

  // Register window contents as seen by a read launched this cycle.
  always_comb begin
    w_reg_rdata = 32'd0;
    case (bus.address)
      A_STATUS: w_reg_rdata = {w_frame_ext, 13'd0, r_gfx_bank, r_vblank_q, r_irq_pending};
      A_CTRL:   w_reg_rdata = {30'd0, r_gfx_bank, r_irq_en};
      default:  w_reg_rdata = 32'd0;
    endcase
  end

  // Return-data mux keyed by the held one-hot memory select.
  always_comb begin
    w_mem_rdata = 32'd0;
    case (o_mem_sel)
      SEL_TBUF: w_mem_rdata = i_tile_buffer_rdata;
      SEL_TGFX: w_mem_rdata = i_tile_graphics_rdata;
      SEL_SGFX: w_mem_rdata = i_sprite_graphics_rdata;
      SEL_OAM:  w_mem_rdata = i_oam_rdata;
      SEL_PAL:  w_mem_rdata = {8'd0, i_palette_rdata};
      default:  w_mem_rdata = 32'd0;
    endcase
  end

  // Read FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Read FSM next-state and strobes.
  always_comb begin
    w_next        = r_state;
    w_start_mem   = 1'b0;
    w_start_reg   = 1'b0;
    w_capture_mem = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rd_req) begin
          if (w_sel_dec == 5'b00000) begin
            w_next      = S_DONE;
            w_start_reg = 1'b1;
          end else if (w_mem_ok) begin
            w_next      = S_ISSUE;
            w_start_mem = 1'b1;
          end else begin
            w_next = S_IDLE;
          end
        end else begin
          w_next = S_IDLE;
        end
      end
      S_ISSUE: w_next = S_WAIT;
      S_WAIT: begin
        if (r_cnt == 2'd0) begin
          w_next        = S_DONE;
          w_capture_mem = 1'b1;
        end else begin
          w_next = S_WAIT;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_pend_set = w_vb_rise && r_irq_en;
  assign w_pend_clr = ((r_state == S_DONE) && r_status_rd) ||
                      (w_wr_req && (bus.address == A_IRQ_ACK) && bus.write_data[0]);

  // Datapath: memory port, read capture, control/status registers and frame counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_mem_sel     <= 5'd0;
      o_mem_rd      <= 1'b0;
      o_mem_addr    <= 11'd0;
      r_cnt         <= 2'd0;
      r_readdata    <= 32'd0;
      r_status_rd   <= 1'b0;
      r_irq_en      <= 1'b0;
      r_gfx_bank    <= 1'b0;
      r_irq_pending <= 1'b0;
      r_vblank_q    <= 1'b0;
      r_frame_count <= '0;
      o_irq         <= 1'b0;
    end else begin
      o_mem_rd   <= w_start_mem;
      r_vblank_q <= i_vblank;
      o_irq      <= r_irq_pending && r_irq_en;

      if (w_start_mem) begin
        o_mem_sel  <= w_sel_dec;
        o_mem_addr <= f_mem_index(bus.address);
      end else if (w_capture_mem) begin
        o_mem_sel  <= 5'd0;
        o_mem_addr <= 11'd0;
      end

      if (r_state == S_ISSUE) begin
        r_cnt <= LAT_M1;
      end else if ((r_state == S_WAIT) && (r_cnt != 2'd0)) begin
        r_cnt <= r_cnt - 2'd1;
      end

      if (w_start_reg) begin
        r_readdata  <= w_reg_rdata;
        r_status_rd <= (bus.address == A_STATUS);
      end else if (w_capture_mem) begin
        r_readdata  <= w_mem_rdata;
        r_status_rd <= 1'b0;
      end

      if (w_wr_req && (bus.address == A_CTRL)) begin
        r_irq_en   <= bus.write_data[0];
        r_gfx_bank <= bus.write_data[1];
      end

      // A vblank set beats a simultaneous acknowledge.
      if (w_pend_set) begin
        r_irq_pending <= 1'b1;
      end else if (w_pend_clr) begin
        r_irq_pending <= 1'b0;
      end

      if (w_vb_rise) begin
        r_frame_count <= r_frame_count + FRAME_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ppu_cpu_readback.sv
// Self-checking bench for ppu_cpu_readback: address-map vector table, directed
// corner sequences and randomized traffic against a behavioural model.
module tb_ppu_cpu_readback;
  localparam int TB_LAT = 3;
  localparam int TB_FW  = 8;
  localparam logic [11:0] A_STATUS = 12'h3F0;
  localparam logic [11:0] A_CTRL   = 12'h3F1;
  localparam logic [11:0] A_ACK    = 12'h3F2;

  typedef struct {
    logic [11:0] addr;
    logic        bank;
    logic [4:0]  sel;
    logic [10:0] maddr;
    int          lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vblank = 1'b0;
  logic        irq;
  logic        mem_rd;
  logic [4:0]  mem_sel;
  logic [10:0] mem_addr;
  logic [31:0] tb_rd, tg_rd, sg_rd, oam_rd;
  logic [23:0] pal_rd;
  logic [31:0] v_tb, v_tg, v_sg, v_oam;
  logic [23:0] v_pal;

  int checks = 0;
  int failures = 0;

  // behavioural model state
  int m_frame;
  bit m_en, m_bank, m_pend, m_vb;

  logic [31:0] res_d;
  int          res_lat, res_pulses;
  logic [4:0]  res_sel;
  logic [10:0] res_maddr;
  vec_t        vecs [17];

  ppu_cpu_readback_if bus_if();

  ppu_cpu_readback #(.MEM_LAT(TB_LAT), .FRAME_W(TB_FW)) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .bus                     (bus_if),
    .i_vblank                (vblank),
    .o_irq                   (irq),
    .o_mem_sel               (mem_sel),
    .o_mem_rd                (mem_rd),
    .o_mem_addr              (mem_addr),
    .i_tile_buffer_rdata     (tb_rd),
    .i_tile_graphics_rdata   (tg_rd),
    .i_sprite_graphics_rdata (sg_rd),
    .i_oam_rdata             (oam_rd),
    .i_palette_rdata         (pal_rd)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic rand_vals();
    v_tb  = $urandom;
    v_tg  = $urandom;
    v_sg  = $urandom;
    v_oam = $urandom;
    v_pal = 24'($urandom);
  endtask

  // Memories present the true word only in the cycle they would deliver it.
  task automatic drive_mem(input bit valid);
    if (valid) begin
      tb_rd = v_tb; tg_rd = v_tg; sg_rd = v_sg; oam_rd = v_oam; pal_rd = v_pal;
    end else begin
      tb_rd = ~v_tb; tg_rd = ~v_tg; sg_rd = ~v_sg; oam_rd = ~v_oam; pal_rd = ~v_pal;
    end
  endtask

  function automatic bit is_mem(input logic [11:0] a);
    return (a < 12'h308) || (a >= 12'h800);
  endfunction

  function automatic logic [31:0] exp_read(input logic [11:0] a);
    if (a < 12'h200)       return v_tb;
    else if (a < 12'h300)  return v_oam;
    else if (a < 12'h308)  return {8'h00, v_pal};
    else if (a == A_STATUS) return {16'(m_frame), 13'd0, m_bank, m_vb, m_pend};
    else if (a == A_CTRL)  return {30'd0, m_bank, m_en};
    else if (a >= 12'h800) return m_bank ? v_sg : v_tg;
    else                   return 32'd0;
  endfunction

  task automatic bus_read(input logic [11:0] a, input bit inject, input logic [1:0] inj);
    bit done = 1'b0;
    res_d = 32'd0; res_lat = 0; res_pulses = 0; res_sel = 5'd0; res_maddr = 11'd0;
    @(negedge clk);
    drive_mem(1'b0);
    bus_if.chipselect = 1'b1; bus_if.read = 1'b1; bus_if.write = 1'b0; bus_if.address = a;
    for (int k = 1; k <= 24 && !done; k++) begin
      @(negedge clk);
      if (mem_rd) begin
        res_pulses++; res_sel = mem_sel; res_maddr = mem_addr;
      end
      if (bus_if.read && !bus_if.waitrequest) begin
        done = 1'b1; res_d = bus_if.readdata; res_lat = k;
        bus_if.chipselect = 1'b0; bus_if.read = 1'b0;
      end else if (inject && k == 2) begin
        bus_if.read = 1'b0; bus_if.write = 1'b1; bus_if.address = A_CTRL;
        bus_if.write_data = {30'd0, inj};
      end else if (inject && k == 3) begin
        bus_if.read = 1'b1; bus_if.write = 1'b0; bus_if.address = a;
      end
      drive_mem(k == TB_LAT + 1);
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL read_timeout addr=0x%03h actual=no-ack required=ack", a);
      bus_if.chipselect = 1'b0; bus_if.read = 1'b0;
    end
  endtask

  task automatic bus_write(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_if.chipselect = 1'b1; bus_if.write = 1'b1; bus_if.read = 1'b0;
    bus_if.address = a; bus_if.write_data = d;
    @(negedge clk);
    bus_if.chipselect = 1'b0; bus_if.write = 1'b0;
    if (a == A_CTRL) begin
      m_en = d[0]; m_bank = d[1];
    end else if (a == A_ACK && d[0]) begin
      m_pend = 1'b0;
    end
  endtask

  task automatic vblank_set(input bit v);
    @(negedge clk);
    vblank = v;
    if (v && !m_vb) begin
      m_frame = (m_frame + 1) % (1 << TB_FW);
      if (m_en) m_pend = 1'b1;
    end
    m_vb = v;
    idle(2);
  endtask

  initial begin
    logic [11:0] a;
    logic [31:0] e;
    int          op, rs;

    vecs[0]  = '{12'h005, 1'b0, 5'b00001, 11'h005, TB_LAT + 2};
    vecs[1]  = '{12'h1FF, 1'b0, 5'b00001, 11'h1FF, TB_LAT + 2};
    vecs[2]  = '{12'h200, 1'b0, 5'b01000, 11'h000, TB_LAT + 2};
    vecs[3]  = '{12'h2FF, 1'b1, 5'b01000, 11'h0FF, TB_LAT + 2};
    vecs[4]  = '{12'h300, 1'b0, 5'b10000, 11'h000, TB_LAT + 2};
    vecs[5]  = '{12'h307, 1'b1, 5'b10000, 11'h007, TB_LAT + 2};
    vecs[6]  = '{12'h308, 1'b0, 5'b00000, 11'h000, 1};
    vecs[7]  = '{12'h3EF, 1'b0, 5'b00000, 11'h000, 1};
    vecs[8]  = '{12'h3F1, 1'b1, 5'b00000, 11'h000, 1};
    vecs[9]  = '{12'h3F2, 1'b0, 5'b00000, 11'h000, 1};
    vecs[10] = '{12'h3F3, 1'b0, 5'b00000, 11'h000, 1};
    vecs[11] = '{12'h400, 1'b1, 5'b00000, 11'h000, 1};
    vecs[12] = '{12'h7FF, 1'b0, 5'b00000, 11'h000, 1};
    vecs[13] = '{12'h800, 1'b0, 5'b00010, 11'h000, TB_LAT + 2};
    vecs[14] = '{12'hFFF, 1'b1, 5'b00100, 11'h7FF, TB_LAT + 2};
    vecs[15] = '{12'h805, 1'b1, 5'b00100, 11'h005, TB_LAT + 2};
    vecs[16] = '{12'hABC, 1'b0, 5'b00010, 11'h2BC, TB_LAT + 2};

    bus_if.chipselect = 1'b0; bus_if.read = 1'b0; bus_if.write = 1'b0;
    bus_if.address = 12'd0; bus_if.write_data = 32'd0;
    m_frame = 0; m_en = 1'b0; m_bank = 1'b0; m_pend = 1'b0; m_vb = 1'b0;
    rand_vals();
    drive_mem(1'b0);

    idle(3);
    chk("rst_readdata", bus_if.readdata, 32'd0);
    chk("rst_waitreq", {31'd0, bus_if.waitrequest}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_mem_sel", {27'd0, mem_sel}, 32'd0);
    chk("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("rst_mem_addr", {21'd0, mem_addr}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    idle(2);

    rand_vals(); v_tb = 32'hDEADBEEF;
    bus_read(12'h005, 1'b0, 2'b00);
    chk("tbuf_data", res_d, 32'hDEADBEEF);
    chk("tbuf_lat", res_lat, TB_LAT + 2);
    chk("tbuf_pulses", res_pulses, 1);
    chk("tbuf_sel", {27'd0, res_sel}, 32'h1);
    chk("tbuf_addr", {21'd0, res_maddr}, 32'h5);

    for (int i = 0; i < 17; i++) begin
      bus_write(A_CTRL, {30'd0, vecs[i].bank, 1'b0});
      rand_vals();
      e = exp_read(vecs[i].addr);
      bus_read(vecs[i].addr, 1'b0, 2'b00);
      chk($sformatf("vec%0d_data", i), res_d, e);
      chk($sformatf("vec%0d_lat", i), res_lat, vecs[i].lat);
      chk($sformatf("vec%0d_pulses", i), res_pulses, (vecs[i].sel != 5'd0) ? 1 : 0);
      chk($sformatf("vec%0d_sel", i), {27'd0, res_sel}, {27'd0, vecs[i].sel});
      chk($sformatf("vec%0d_addr", i), {21'd0, res_maddr}, {21'd0, vecs[i].maddr});
    end

    rand_vals(); v_pal = 24'hABCDEF;
    bus_read(12'h304, 1'b0, 2'b00);
    chk("pal_zext", res_d, 32'h00ABCDEF);

    // CTRL rewritten mid-read must not redirect the in-flight graphics read
    bus_write(A_CTRL, 32'h3);
    rand_vals();
    bus_read(12'h805, 1'b1, 2'b01);
    m_en = 1'b1; m_bank = 1'b0;
    chk("inflight_data", res_d, v_sg);
    chk("inflight_sel", {27'd0, res_sel}, 32'h4);
    chk("inflight_addr", {21'd0, res_maddr}, 32'h5);
    bus_read(A_CTRL, 1'b0, 2'b00);
    chk("inflight_ctrl", res_d, 32'h1);

    bus_write(A_CTRL, 32'h1);
    vblank_set(1'b1);
    chk("irq_set", {31'd0, irq}, 32'd1);
    bus_read(A_STATUS, 1'b0, 2'b00);
    m_pend = 1'b0;
    chk("status_irq", res_d, 32'h00010003);
    idle(2);
    chk("irq_cleared_by_status", {31'd0, irq}, 32'd0);
    vblank_set(1'b0);
    bus_write(A_CTRL, 32'h0);
    vblank_set(1'b1);
    chk("irq_disabled", {31'd0, irq}, 32'd0);
    bus_read(A_STATUS, 1'b0, 2'b00);
    chk("status_noirq", res_d, 32'h00020002);
    vblank_set(1'b0);

    // vblank set and IRQ_ACK in the same cycle: set wins
    bus_write(A_CTRL, 32'h1);
    @(negedge clk);
    vblank = 1'b1;
    bus_if.chipselect = 1'b1; bus_if.write = 1'b1; bus_if.read = 1'b0;
    bus_if.address = A_ACK; bus_if.write_data = 32'h1;
    @(negedge clk);
    bus_if.chipselect = 1'b0; bus_if.write = 1'b0;
    m_vb = 1'b1; m_frame = (m_frame + 1) % (1 << TB_FW); m_pend = 1'b1;
    idle(2);
    chk("setclr_irq", {31'd0, irq}, 32'd1);
    bus_read(A_STATUS, 1'b0, 2'b00);
    m_pend = 1'b0;
    chk("setclr_pending", {31'd0, res_d[0]}, 32'd1);
    vblank_set(1'b0);

    for (int it = 0; it < 60; it++) begin
      op = $urandom_range(0, 4);
      case (op)
        0, 1: begin
          rs = $urandom_range(0, 5);
          case (rs)
            0:       a = 12'($urandom_range(0, 12'h307));
            1:       a = 12'($urandom_range(12'h800, 12'hFFF));
            2:       a = A_STATUS;
            3:       a = A_CTRL;
            4:       a = 12'($urandom_range(12'h308, 12'h7FF));
            default: a = 12'($urandom);
          endcase
          rand_vals();
          e = exp_read(a);
          bus_read(a, 1'b0, 2'b00);
          chk($sformatf("rnd%0d_data_%03h", it, a), res_d, e);
          chk($sformatf("rnd%0d_lat", it), res_lat, is_mem(a) ? TB_LAT + 2 : 1);
          if (a == A_STATUS) m_pend = 1'b0;
        end
        2:       bus_write(A_CTRL, 32'($urandom_range(0, 3)));
        3:       vblank_set(!m_vb);
        default: bus_write(A_ACK, 32'($urandom_range(0, 1)));
      endcase
      idle(2);
      chk($sformatf("rnd%0d_irq", it), {31'd0, irq}, {31'd0, m_pend & m_en});
    end

    // asynchronous reset in the middle of a memory read
    bus_write(A_CTRL, 32'h1);
    if (m_vb) vblank_set(1'b0);
    vblank_set(1'b1);
    idle(1);
    chk("pre_rst_irq", {31'd0, irq}, 32'd1);
    @(negedge clk);
    bus_if.chipselect = 1'b1; bus_if.read = 1'b1; bus_if.address = 12'h100;
    idle(2);
    chk("pre_rst_sel", {27'd0, mem_sel}, 32'h1);
    rst_n = 1'b0; vblank = 1'b0;
    #1;
    chk("rst_wait_waitreq", {31'd0, bus_if.waitrequest}, 32'd0);
    chk("rst_wait_sel", {27'd0, mem_sel}, 32'd0);
    chk("rst_wait_irq", {31'd0, irq}, 32'd0);
    bus_if.chipselect = 1'b0; bus_if.read = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    m_frame = 0; m_en = 1'b0; m_bank = 1'b0; m_pend = 1'b0; m_vb = 1'b0;
    idle(2);

    for (int i = 0; i < 255; i++) begin
      @(negedge clk); vblank = 1'b1;
      @(negedge clk); vblank = 1'b0;
    end
    idle(1);
    bus_read(A_STATUS, 1'b0, 2'b00);
    chk("frame_255", {16'd0, res_d[31:16]}, 32'd255);
    @(negedge clk); vblank = 1'b1;
    @(negedge clk); vblank = 1'b0;
    idle(1);
    bus_read(A_STATUS, 1'b0, 2'b00);
    chk("frame_wrap", {16'd0, res_d[31:16]}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
